// File: rtl/adsr_beat_scheduler.sv
// Sequencing block for the ADSR pixel filter: tick generator, BPM-to-period serial
// divider, and the per-beat ADSR envelope state machine that produces env_gain.
module adsr_beat_scheduler #(
    parameter int BITS         = 8,
    parameter int TICK_CYCLES  = 200000,
    parameter int BPM_MIN      = 30,
    parameter int BPM_MAX      = 200,
    parameter int ATTACK_STEP  = 16,
    parameter int DECAY_STEP   = 4,
    parameter int SUSTAIN_FRAC = 160,
    parameter int RELEASE_STEP = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            filter_enable_i,
    input  logic [7:0]      bpm_estimate_i,
    input  logic [BITS-1:0] pulse_amplitude_i,
    output logic            tick_4ms_o,
    output logic            beat_pulse_o,
    output logic [2:0]      state_o,
    output logic [BITS-1:0] env_gain_o,
    output logic [13:0]     adsr_counter_o,
    output logic [13:0]     beat_ticks_o,
    output logic            div_busy_o
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int PW = BITS + 8;
    localparam int DIV_ITERS = 14;
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
    localparam logic [13:0]   DIVIDEND    = 14'd15000;
    localparam logic [7:0]    BPM_RESET   = 8'd100;
    localparam logic [13:0]   TICKS_RESET = 14'd150;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } adsr_state_e;

    // ---------------- tick generator ----------------
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d     = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_d ? '0 : tick_cnt_q + TW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
        end
    end

    // ---------------- BPM clamp ----------------
    logic [7:0] bpm_clamped;

    always_comb begin
        bpm_clamped = bpm_estimate_i;
        if (bpm_estimate_i < 8'(BPM_MIN)) begin
            bpm_clamped = 8'(BPM_MIN);
        end else if (bpm_estimate_i > 8'(BPM_MAX)) begin
            bpm_clamped = 8'(BPM_MAX);
        end
    end

    // ---------------- envelope / beat signals ----------------
    adsr_state_e     state_q, state_d;
    logic [BITS-1:0] gain_q, gain_d;
    logic [13:0]     cnt_q, cnt_d, cnt_inc;
    logic [13:0]     beat_ticks_q, beat_ticks_d;
    logic            armed_q, armed_d;
    logic            beat_pulse;

    // armed_q marks that the next tick must open a beat (after reset or re-enable).
    assign beat_pulse = tick_q & filter_enable_i &
                        (armed_q | (cnt_q == beat_ticks_q - 14'd1));

    // ---------------- restoring divider 15000 / bpm ----------------
    logic        div_busy_q, div_busy_d;
    logic [3:0]  div_iter_q, div_iter_d;
    logic [7:0]  div_den_q, div_den_d;
    logic [7:0]  div_rem_q, div_rem_d;
    logic [13:0] div_dq_q, div_dq_d;
    logic [7:0]  last_bpm_q, last_bpm_d;
    logic [13:0] pending_ticks_q, pending_ticks_d;
    logic        pending_valid_q, pending_valid_d;
    logic [8:0]  rem_shift;
    logic        rem_ge;

    always_comb begin
        div_busy_d      = div_busy_q;
        div_iter_d      = div_iter_q;
        div_den_d       = div_den_q;
        div_rem_d       = div_rem_q;
        div_dq_d        = div_dq_q;
        last_bpm_d      = last_bpm_q;
        pending_ticks_d = pending_ticks_q;
        pending_valid_d = pending_valid_q;
        rem_shift       = {div_rem_q, div_dq_q[13]};
        rem_ge          = (rem_shift >= {1'b0, div_den_q});

        if (beat_pulse) begin
            pending_valid_d = 1'b0;
        end

        // div_dq_q shifts dividend bits out the top and quotient bits in the bottom.
        if (div_busy_q) begin
            div_rem_d  = rem_ge ? 8'(rem_shift - {1'b0, div_den_q}) : rem_shift[7:0];
            div_dq_d   = {div_dq_q[12:0], rem_ge};
            div_iter_d = div_iter_q + 4'd1;
            if (div_iter_q == 4'(DIV_ITERS - 1)) begin
                div_busy_d      = 1'b0;
                pending_ticks_d = {div_dq_q[12:0], rem_ge};
                pending_valid_d = 1'b1;
            end
        end else if (bpm_clamped != last_bpm_q) begin
            div_busy_d = 1'b1;
            div_iter_d = '0;
            div_den_d  = bpm_clamped;
            div_rem_d  = '0;
            div_dq_d   = DIVIDEND;
            last_bpm_d = bpm_clamped;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_busy_q      <= 1'b0;
            div_iter_q      <= '0;
            div_den_q       <= '0;
            div_rem_q       <= '0;
            div_dq_q        <= '0;
            last_bpm_q      <= BPM_RESET;
            pending_ticks_q <= '0;
            pending_valid_q <= 1'b0;
        end else begin
            div_busy_q      <= div_busy_d;
            div_iter_q      <= div_iter_d;
            div_den_q       <= div_den_d;
            div_rem_q       <= div_rem_d;
            div_dq_q        <= div_dq_d;
            last_bpm_q      <= last_bpm_d;
            pending_ticks_q <= pending_ticks_d;
            pending_valid_q <= pending_valid_d;
        end
    end

    // ---------------- envelope FSM ----------------
    logic [PW-1:0]   sus_prod;
    logic [BITS-1:0] sus_level;
    logic [BITS:0]   attack_sum;

    always_comb begin
        sus_prod  = PW'(pulse_amplitude_i) * PW'(SUSTAIN_FRAC);
        sus_level = BITS'(sus_prod >> 8);
    end

    always_comb begin
        state_d      = state_q;
        gain_d       = gain_q;
        cnt_d        = cnt_q;
        armed_d      = armed_q;
        beat_ticks_d = beat_ticks_q;
        cnt_inc      = cnt_q + 14'd1;
        attack_sum   = {1'b0, gain_q} + (BITS+1)'(ATTACK_STEP);

        if (!filter_enable_i) begin
            state_d = S_IDLE;
            gain_d  = '0;
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (tick_q) begin
            if (beat_pulse) begin
                // Retrigger keeps the current gain; the new period lands only here.
                cnt_d   = '0;
                armed_d = 1'b0;
                state_d = S_ATTACK;
                if (pending_valid_q) begin
                    beat_ticks_d = pending_ticks_q;
                end
            end else begin
                cnt_d = cnt_inc;
                unique case (state_q)
                    S_ATTACK: begin
                        if (attack_sum >= {1'b0, pulse_amplitude_i}) begin
                            gain_d  = pulse_amplitude_i;
                            state_d = S_DECAY;
                        end else begin
                            gain_d = attack_sum[BITS-1:0];
                        end
                    end
                    S_DECAY: begin
                        if ({1'b0, gain_q} <= {1'b0, sus_level} + (BITS+1)'(DECAY_STEP)) begin
                            gain_d  = sus_level;
                            state_d = S_SUSTAIN;
                        end else begin
                            gain_d = gain_q - BITS'(DECAY_STEP);
                        end
                    end
                    S_SUSTAIN: begin
                        gain_d = sus_level;
                        if (cnt_inc >= {1'b0, beat_ticks_q[13:1]}) begin
                            state_d = S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        if (gain_q <= BITS'(RELEASE_STEP)) begin
                            gain_d  = '0;
                            state_d = S_IDLE;
                        end else begin
                            gain_d = gain_q - BITS'(RELEASE_STEP);
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            gain_q       <= '0;
            cnt_q        <= '0;
            armed_q      <= 1'b1;
            beat_ticks_q <= TICKS_RESET;
        end else begin
            state_q      <= state_d;
            gain_q       <= gain_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            beat_ticks_q <= beat_ticks_d;
        end
    end

    assign tick_4ms_o     = tick_q;
    assign beat_pulse_o   = beat_pulse;
    assign state_o        = state_q;
    assign env_gain_o     = gain_q;
    assign adsr_counter_o = cnt_q;
    assign beat_ticks_o   = beat_ticks_q;
    assign div_busy_o     = div_busy_q;

endmodule

// File: tb/tb_adsr_beat_scheduler.sv
// Bench for adsr_beat_scheduler: directed scenario tasks plus a randomized run
// checked cycle by cycle against a tick-level behavioural model.
module tb_adsr_beat_scheduler;

    localparam int TICKS = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  bpm;
    logic [7:0]  amp;
    logic        tick_4ms_o;
    logic        beat_pulse_o;
    logic [2:0]  state_o;
    logic [7:0]  env_gain_o;
    logic [13:0] adsr_counter_o;
    logic [13:0] beat_ticks_o;
    logic        div_busy_o;

    int checks = 0;
    int errors = 0;
    logic [13:0] exp_q[$];

    always #5 clk = ~clk;

    adsr_beat_scheduler #(.BITS(8), .TICK_CYCLES(TICKS)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .filter_enable_i   (en),
        .bpm_estimate_i    (bpm),
        .pulse_amplitude_i (amp),
        .tick_4ms_o        (tick_4ms_o),
        .beat_pulse_o      (beat_pulse_o),
        .state_o           (state_o),
        .env_gain_o        (env_gain_o),
        .adsr_counter_o    (adsr_counter_o),
        .beat_ticks_o      (beat_ticks_o),
        .div_busy_o        (div_busy_o)
    );

    // ---------------- behavioural model (tick-level, plain integers) ----------------
    typedef struct packed {
        int tcnt; int tick; int armed; int cnt; int bt; int pend; int pend_v;
        int last; int busy_left; int res; int state; int gain;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r       = '0;
        r.bt    = 150;
        r.last  = 100;
        r.armed = 1;
        return r;
    endfunction

    function automatic int clamp_bpm(int v);
        if (v < 30) return 30;
        if (v > 200) return 200;
        return v;
    endfunction

    function automatic int model_beat(model_t c, logic e);
        return (c.tick != 0 && e && (c.armed != 0 || c.cnt == c.bt - 1)) ? 1 : 0;
    endfunction

    function automatic model_t model_next(model_t c, logic e, logic [7:0] bpm_v, logic [7:0] amp_v);
        model_t n;
        int b, a, sus, g;
        n   = c;
        a   = int'(amp_v);
        b   = clamp_bpm(int'(bpm_v));
        sus = (a * 160) / 256;
        n.tick = (c.tcnt == TICKS - 1) ? 1 : 0;
        n.tcnt = (c.tcnt + 1) % TICKS;
        if (!e) begin
            n.state = 0; n.gain = 0; n.cnt = 0; n.armed = 1;
        end else if (c.tick != 0) begin
            if (model_beat(c, e) != 0) begin
                n.cnt = 0; n.armed = 0; n.state = 1;
                if (c.pend_v != 0) begin n.bt = c.pend; n.pend_v = 0; end
            end else begin
                n.cnt = c.cnt + 1;
                case (c.state)
                    1: begin g = c.gain + 16; if (g >= a) begin n.gain = a; n.state = 2; end else n.gain = g; end
                    2: begin g = c.gain - 4; if (g <= sus) begin n.gain = sus; n.state = 3; end else n.gain = g; end
                    3: begin n.gain = sus; if (n.cnt >= c.bt / 2) n.state = 4; end
                    4: begin g = c.gain - 8; if (g <= 0) begin n.gain = 0; n.state = 0; end else n.gain = g; end
                    default: ;
                endcase
            end
        end
        if (c.busy_left > 0) begin
            n.busy_left = c.busy_left - 1;
            if (n.busy_left == 0) begin n.pend = c.res; n.pend_v = 1; end
        end else if (b != c.last) begin
            n.last = b; n.busy_left = 14; n.res = 15000 / b;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, en, bpm, amp);
    end

    // Closed-form envelope for amp=128, beat period 150, k ticks after the beat.
    function automatic void env_expect(int k, output int st, output int g);
        if (k < 8)       begin st = 1; g = 16 * k; end
        else if (k < 20) begin st = 2; g = 128 - 4 * (k - 8); end
        else if (k < 75) begin st = 3; g = 80; end
        else if (k < 85) begin st = 4; g = 80 - 8 * (k - 75); end
        else             begin st = 0; g = 0; end
    endfunction

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        int n;
        rst_n = 1'b0; en = 1'b0; bpm = 8'd100; amp = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tick_4ms_o, beat_pulse_o, state_o, env_gain_o, adsr_counter_o, div_busy_o} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {tick_4ms_o, beat_pulse_o, state_o, env_gain_o, adsr_counter_o, div_busy_o});
        end
        checks++;
        if (beat_ticks_o !== 14'd150) begin
            errors++; $display("FAIL reset_beat_ticks got %0d want 150", beat_ticks_o);
        end
        rst_n = 1'b1;
        n = 0;
        while (tick_4ms_o !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (n != TICKS) begin errors++; $display("FAIL first_tick got %0d cycles want %0d", n, TICKS); end
        n = 0;
        do begin @(negedge clk); n++; end while (tick_4ms_o !== 1'b1 && n < 30);
        checks++;
        if (n != TICKS) begin errors++; $display("FAIL tick_period got %0d cycles want %0d", n, TICKS); end
        @(negedge clk);
        checks++;
        if (tick_4ms_o !== 1'b0) begin errors++; $display("FAIL tick_width got %b want 0", tick_4ms_o); end
    endtask

    task automatic test_bpm_update();
        int n, nb;
        checks++;
        if (div_busy_o !== 1'b0) begin errors++; $display("FAIL same_bpm_busy got %b want 0", div_busy_o); end
        bpm = 8'd180;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_busy_o === 1'b1) nb++;
        end
        checks++;
        if (nb != 14) begin errors++; $display("FAIL div_busy_len got %0d want 14", nb); end
        checks++;
        if (beat_ticks_o !== 14'd150) begin errors++; $display("FAIL early_update got %0d want 150", beat_ticks_o); end
        en = 1'b1;
        n = 0;
        while (beat_pulse_o !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (beat_pulse_o !== 1'b1) begin errors++; $display("FAIL bpm_beat_timeout got %b want 1", beat_pulse_o); end
        checks++;
        if (beat_ticks_o !== 14'd150) begin errors++; $display("FAIL at_beat_ticks got %0d want 150", beat_ticks_o); end
        @(negedge clk);
        checks++;
        if (beat_ticks_o !== 14'd83) begin errors++; $display("FAIL after_beat_ticks got %0d want 83", beat_ticks_o); end
    endtask

    task automatic test_clamp();
        logic [7:0] vals [2];
        logic [13:0] want;
        int n;
        vals[0] = 8'd0;
        vals[1] = 8'd250;
        exp_q.push_back(14'd500);
        exp_q.push_back(14'd75);
        for (int i = 0; i < 2; i++) begin
            bpm = vals[i];
            repeat (40) @(negedge clk);
            en = 1'b0;
            repeat (2) @(negedge clk);
            en = 1'b1;
            n = 0;
            while (beat_pulse_o !== 1'b1 && n < 30) begin @(negedge clk); n++; end
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (beat_ticks_o !== want) begin
                errors++; $display("FAIL clamp_bpm_%0d got %0d want %0d", vals[i], beat_ticks_o, want);
            end
        end
    endtask

    task automatic test_envelope();
        int n, st, g;
        rst_n = 1'b0; bpm = 8'd100; amp = 8'd128; en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (beat_pulse_o !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (beat_pulse_o !== 1'b1) begin errors++; $display("FAIL env_beat_timeout got %b want 1", beat_pulse_o); end
        for (int k = 0; k <= 90; k++) begin
            if (k > 0) begin
                n = 0;
                while (tick_4ms_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            end
            @(negedge clk);
            env_expect(k, st, g);
            checks++;
            if (state_o !== 3'(st) || env_gain_o !== 8'(g) || adsr_counter_o !== 14'(k)) begin
                errors++;
                $display("FAIL envelope_k%0d got st=%0d gain=%0d cnt=%0d want st=%0d gain=%0d cnt=%0d",
                         k, state_o, env_gain_o, adsr_counter_o, st, g, k);
            end
        end
    endtask

    task automatic test_enable_drop();
        int n;
        logic seen;
        n = 0;
        while (beat_pulse_o !== 1'b1 && n < 800) begin @(negedge clk); n++; end
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            n = 0;
            while (tick_4ms_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        end
        @(negedge clk);
        checks++;
        if (state_o !== 3'd2) begin errors++; $display("FAIL pre_drop_state got %0d want 2", state_o); end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (state_o !== 3'd0 || env_gain_o !== 8'd0 || adsr_counter_o !== 14'd0 || beat_pulse_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_clear got st=%0d gain=%0d cnt=%0d beat=%b want 0 0 0 0",
                     state_o, env_gain_o, adsr_counter_o, beat_pulse_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (beat_pulse_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL beat_while_disabled got 1 want 0"); end
        en = 1'b1;
        n = 0;
        while (tick_4ms_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (beat_pulse_o !== 1'b1) begin errors++; $display("FAIL reenable_beat got %b want 1", beat_pulse_o); end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            n = 0;
            while (tick_4ms_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        end
        @(negedge clk);
        checks++;
        if (state_o !== 3'd1 || env_gain_o !== 8'd48) begin
            errors++; $display("FAIL mid_attack got st=%0d gain=%0d want 1 48", state_o, env_gain_o);
        end
        bpm = 8'd60;
        repeat (5) @(negedge clk);
        checks++;
        if (div_busy_o !== 1'b1) begin errors++; $display("FAIL mid_divide_busy got %b want 1", div_busy_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tick_4ms_o, beat_pulse_o, state_o, env_gain_o, adsr_counter_o, div_busy_o} !== 28'd0
            || beat_ticks_o !== 14'd150) begin
            errors++;
            $display("FAIL async_reset got outs=%h ticks=%0d want 0 150",
                     {tick_4ms_o, beat_pulse_o, state_o, env_gain_o, adsr_counter_o, div_busy_o}, beat_ticks_o);
        end
        bpm = 8'd100;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (tick_4ms_o !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (beat_pulse_o !== 1'b1) begin errors++; $display("FAIL post_reset_beat got %b want 1", beat_pulse_o); end
        @(negedge clk);
        checks++;
        if (beat_ticks_o !== 14'd150 || div_busy_o !== 1'b0) begin
            errors++; $display("FAIL stale_update got ticks=%0d busy=%b want 150 0", beat_ticks_o, div_busy_o);
        end
    endtask

    task automatic test_random();
        logic exp_beat;
        rst_n = 1'b0; en = 1'b1; bpm = 8'd100; amp = 8'($urandom_range(0, 255));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            exp_beat = (model_beat(m, en) != 0);
            checks++;
            if (tick_4ms_o !== (m.tick != 0)) begin
                errors++; $display("FAIL rnd_tick cyc=%0d got %b want %0d", i, tick_4ms_o, m.tick);
            end
            checks++;
            if (beat_pulse_o !== exp_beat) begin
                errors++; $display("FAIL rnd_beat cyc=%0d got %b want %b", i, beat_pulse_o, exp_beat);
            end
            checks++;
            if (state_o !== 3'(m.state)) begin
                errors++; $display("FAIL rnd_state cyc=%0d got %0d want %0d", i, state_o, m.state);
            end
            checks++;
            if (env_gain_o !== 8'(m.gain)) begin
                errors++; $display("FAIL rnd_gain cyc=%0d got %0d want %0d", i, env_gain_o, m.gain);
            end
            checks++;
            if (adsr_counter_o !== 14'(m.cnt)) begin
                errors++; $display("FAIL rnd_counter cyc=%0d got %0d want %0d", i, adsr_counter_o, m.cnt);
            end
            checks++;
            if (beat_ticks_o !== 14'(m.bt)) begin
                errors++; $display("FAIL rnd_beat_ticks cyc=%0d got %0d want %0d", i, beat_ticks_o, m.bt);
            end
            checks++;
            if (div_busy_o !== (m.busy_left > 0)) begin
                errors++; $display("FAIL rnd_busy cyc=%0d got %b want %0d", i, div_busy_o, m.busy_left);
            end
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 299) == 0) begin
                if ($urandom_range(0, 1) == 0) bpm = 8'($urandom_range(0, 255));
                else                           bpm = 8'($urandom_range(150, 255));
            end
            if ($urandom_range(0, 49) == 0) amp = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bpm_update();
        test_clamp();
        test_envelope();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
